// File: rtl/ram_port_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU port (C) and the loader port (L).
// Latency: ack two cycles after the IDLE grant. Backpressure: the loser's request is held off (c_stall for C).
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic [DATA_WIDTH-1:0] c_rdata,
    output logic                  c_ack,
    output logic                  c_stall,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [DATA_WIDTH-1:0] l_wdata,
    output logic [DATA_WIDTH-1:0] l_rdata,
    output logic                  l_ack,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic                  owner_q, owner_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;

    logic c_force, grant_l, grant_c;

    // C overrides L's fixed priority once it has lost MAX_WAIT arbitrations in a row.
    assign c_force = c_req && (wait_cnt_q == MAX_W);
    assign grant_l = l_req && !c_force;
    assign grant_c = c_req && !grant_l;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        owner_d     = owner_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_l) begin
                    state_d     = ISSUE;
                    owner_d     = 1'b1;
                    ram_we_d    = l_we;
                    ram_addr_d  = l_addr;
                    ram_wdata_d = l_wdata;
                    if (c_req && (wait_cnt_q != MAX_W)) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end else if (grant_c) begin
                    state_d     = ISSUE;
                    owner_d     = 1'b0;
                    ram_we_d    = c_we;
                    ram_addr_d  = c_addr;
                    ram_wdata_d = c_wdata;
                    wait_cnt_d  = 4'd0;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= 4'd0;
            owner_q     <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            owner_q     <= owner_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    // Acks decode straight from state so an async reset clears them immediately.
    assign c_ack     = (state_q == RESP) && !owner_q;
    assign l_ack     = (state_q == RESP) && owner_q;
    assign c_rdata   = c_ack ? ram_rdata : '0;
    assign l_rdata   = l_ack ? ram_rdata : '0;
    assign c_stall   = c_req && !c_ack;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule
